// File: rtl/simple_bus_pkg.sv
// Shared types for the simple_bus command-port arbiter.
//   state_e  : sequencer states (IDLE -> ISSUE -> WAIT -> RESP -> IDLE)
//   result_e : outcome of one bus transaction (completed or timed out)
//   SB_CMD_W : default command width of the simple_bus cmd port
package simple_bus_pkg;

  localparam int SB_CMD_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    RES_OK,
    RES_ERR
  } result_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   req_i    : request vector, one bit per requester
//   rr_ptr_i : index of the requester served last; search starts one above it
//   valid_o  : at least one request is pending
//   index_o  : first requesting index found scanning upward from rr_ptr_i+1 with wrap
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] index_o
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest candidate to the nearest so the nearest
  // requester after the pointer is the last one written, i.e. the winner.
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    cand    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDX_W'((int'(rr_ptr_i) + k) % NREQ);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        index_o = cand;
      end
    end
  end

endmodule

// File: rtl/simple_bus_arb.sv
// Round-robin arbiter/sequencer sharing one simple_bus command port.
// One transaction at a time: pick a requester, pulse bus_en/bus_cmd for one
// cycle, wait for a rising edge on bus_done (or a timeout), then pulse ack
// or err back to that requester.
//   clk      : clock, all state on posedge
//   rst_     : asynchronous active-low reset
//   req      : per-requester request level, held until ack/err
//   req_cmd  : packed commands, requester i at [i*CMD_W +: CMD_W]
//   gnt      : one-hot grant, held from ISSUE through RESP
//   ack/err  : one-cycle completion / timeout pulse to the granted requester
//   bus_en   : one-cycle command strobe to simple_bus
//   bus_cmd  : command to simple_bus, holds its last value between strobes
//   bus_done : completion level from simple_bus
//   busy     : sequencer is not idle
module simple_bus_arb
  import simple_bus_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int CMD_W   = SB_CMD_W,
  parameter int TIMEOUT = 32,
  parameter int TO_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CMD_W-1:0] req_cmd,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       err,
  output logic                  bus_en,
  output logic [CMD_W-1:0]      bus_cmd,
  input  logic                  bus_done,
  output logic                  busy
);

  localparam int IDX_W = $clog2(NREQ);

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [NREQ-1:0]  err_q, err_d;
  logic             bus_en_q, bus_en_d;
  logic [CMD_W-1:0] bus_cmd_q, bus_cmd_d;
  logic             busy_q, busy_d;
  logic             done_q;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             done_rise;
  result_e          res;

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_valid),
    .index_o  (pick_idx)
  );

  // Only an edge completes a transaction; a level already high at ISSUE
  // is ignored and the transaction runs into the timeout.
  assign done_rise = bus_done & ~done_q;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    err_d     = '0;
    bus_en_d  = 1'b0;
    bus_cmd_d = bus_cmd_q;
    to_cnt_d  = to_cnt_q;
    rr_ptr_d  = rr_ptr_q;
    sel_d     = sel_q;
    res       = RES_ERR;

    // Outputs are registered, so each output is loaded on the transition
    // into the state in which it must be visible.
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d   = ISSUE;
          sel_d     = pick_idx;
          bus_cmd_d = req_cmd[int'(pick_idx)*CMD_W +: CMD_W];
          bus_en_d  = 1'b1;
          gnt_d     = onehot(pick_idx);
        end
      end
      ISSUE: begin
        state_d  = WAIT;
        to_cnt_d = '0;
      end
      WAIT: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        // Completion is tested first so it wins over a same-cycle timeout.
        if (done_rise) begin
          res     = RES_OK;
          state_d = RESP;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          res     = RES_ERR;
          state_d = RESP;
        end
        if (state_d == RESP) begin
          if (res == RES_OK) ack_d = onehot(sel_q);
          else               err_d = onehot(sel_q);
        end
      end
      RESP: begin
        state_d  = IDLE;
        gnt_d    = '0;
        rr_ptr_d = sel_q;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      bus_en_q  <= 1'b0;
      bus_cmd_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      to_cnt_q  <= '0;
      rr_ptr_q  <= IDX_W'(NREQ - 1);
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      bus_en_q  <= bus_en_d;
      bus_cmd_q <= bus_cmd_d;
      busy_q    <= busy_d;
      done_q    <= bus_done;
      to_cnt_q  <= to_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // Selected index is only meaningful while gnt is set, so it needs no reset.
  always_ff @(posedge clk) begin
    sel_q <= sel_d;
  end

  assign gnt     = gnt_q;
  assign ack     = ack_q;
  assign err     = err_q;
  assign bus_en  = bus_en_q;
  assign bus_cmd = bus_cmd_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_simple_bus_arb.sv
module tb_simple_bus_arb;

  localparam int NREQ    = 4;
  localparam int CMD_W   = 4;
  localparam int TIMEOUT = 32;
  localparam int TO_W    = 6;

  logic                  clk = 1'b0;
  logic                  rst_ = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*CMD_W-1:0] req_cmd = '0;
  logic                  bus_done = 1'b0;
  logic [NREQ-1:0]       gnt, ack, err;
  logic                  bus_en, busy;
  logic [CMD_W-1:0]      bus_cmd;

  int checks = 0;
  int errors = 0;
  int last_srv = NREQ - 1;

  simple_bus_arb #(
    .NREQ(NREQ), .CMD_W(CMD_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rst_(rst_), .req(req), .req_cmd(req_cmd),
    .gnt(gnt), .ack(ack), .err(err), .bus_en(bus_en),
    .bus_cmd(bus_cmd), .bus_done(bus_done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester found scanning upward from last served + 1.
  function automatic int pick(input logic [NREQ-1:0] m, input int ptr);
    for (int k = 1; k <= NREQ; k++)
      if (m[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return 0;
  endfunction

  function automatic logic [CMD_W-1:0] slice(input int i);
    return req_cmd[i*CMD_W +: CMD_W];
  endfunction

  task automatic chk_all_zero(input string tag);
    chk(tag, 32'({gnt, ack, err, bus_en, busy, bus_cmd}), 32'd0);
  endtask

  task automatic do_reset;
    rst_ = 1'b0;
    req = '0;
    bus_done = 1'b0;
    tick;
    chk_all_zero("reset_hold");
    tick;
    rst_ = 1'b1;
    last_srv = NREQ - 1;
  endtask

  // Waits for the command strobe and checks grant, command and latency.
  task automatic wait_issue(input int idx, input logic [CMD_W-1:0] cmd, input string tag);
    int n;
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << idx;
    n = 0;
    do begin
      tick;
      n++;
    end while (bus_en !== 1'b1 && n < 8);
    chk({tag, " latency"}, 32'(n), 32'd1);
    chk({tag, " gnt"}, 32'(gnt), 32'(oh));
    chk({tag, " cmd"}, 32'(bus_cmd), 32'(cmd));
    chk({tag, " busy_en"}, 32'({busy, bus_en, ack, err}), {22'd0, 2'b11, 8'd0});
  endtask

  // Drives bus_done for one transaction (rise d cycles after the strobe,
  // d=0 meaning never, stuck meaning held high) and checks the response.
  task automatic run_resp(input int idx, input logic [CMD_W-1:0] cmd, input int d,
                          input bit stuck, input logic [NREQ-1:0] drop, input string tag);
    bit ok;
    int roff;
    logic [NREQ-1:0] oh;
    ok   = !stuck && d >= 1 && d <= TIMEOUT;
    roff = ok ? d + 1 : TIMEOUT + 1;
    oh   = NREQ'(1) << idx;
    for (int k = 0; k < roff; k++) begin
      bus_done = stuck ? 1'b1 : (d >= 1 && k >= d);
      tick;
      if (k + 1 == roff) begin
        chk({tag, " ack"}, 32'(ack), ok ? 32'(oh) : 32'd0);
        chk({tag, " err"}, 32'(err), ok ? 32'd0 : 32'(oh));
        chk({tag, " gnt_resp"}, 32'({busy, gnt}), 32'({1'b1, oh}));
        chk({tag, " cmd_hold"}, 32'(bus_cmd), 32'(cmd));
        req = req & ~drop;
      end else begin
        chk({tag, " wait"}, 32'({ack, err, bus_en, busy, gnt}),
            32'({NREQ'(0), NREQ'(0), 1'b0, 1'b1, oh}));
      end
    end
    tick;
    chk({tag, " idle"}, 32'({ack, err, gnt, bus_en, busy}), 32'd0);
    bus_done = 1'b0;
    last_srv = idx;
  endtask

  initial begin
    int exp;
    int d;

    // Reset state
    tick;
    chk_all_zero("reset_initial");
    do_reset;

    // Single request, done rises 17 cycles after the strobe
    req_cmd = 16'h0;
    req_cmd[1*CMD_W +: CMD_W] = 4'hA;
    req = 4'b0010;
    wait_issue(1, 4'hA, "single");
    run_resp(1, 4'hA, 17, 1'b0, 4'b0010, "single");

    // Round-robin with all requesters held
    do_reset;
    req_cmd = 16'h7C53;
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp = pick(req, last_srv);
      chk("rr_order", 32'(exp), 32'(t % NREQ));
      wait_issue(exp, slice(exp), "rr");
      run_resp(exp, slice(exp), 2 + t, 1'b0, (t == 4) ? 4'b1111 : 4'b0000, "rr");
    end

    // Timeout with done held low
    req_cmd = 16'h0900;
    req = 4'b0100;
    wait_issue(2, 4'h9, "timeout");
    run_resp(2, 4'h9, 0, 1'b0, 4'b0100, "timeout");

    // Reset in the middle of WAIT
    req_cmd = 16'h0E00;
    req = 4'b0100;
    wait_issue(2, 4'hE, "midrst");
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("midrst wait", 32'({ack, err}), 32'd0);
    end
    #2 rst_ = 1'b0;
    #1;
    chk_all_zero("midrst async");
    req_cmd = 16'h6003;
    req = 4'b1001;
    tick;
    chk_all_zero("midrst held");
    rst_ = 1'b1;
    last_srv = NREQ - 1;
    exp = pick(req, last_srv);
    wait_issue(exp, slice(exp), "post_rst");
    run_resp(exp, slice(exp), 5, 1'b0, 4'b0001, "post_rst");
    exp = pick(req, last_srv);
    wait_issue(exp, slice(exp), "post_rst2");
    run_resp(exp, slice(exp), 9, 1'b0, 4'b1000, "post_rst2");

    // Stuck-high done
    bus_done = 1'b1;
    tick;
    tick;
    req_cmd = 16'h00B0;
    req = 4'b0010;
    wait_issue(1, 4'hB, "stuck");
    run_resp(1, 4'hB, 0, 1'b1, 4'b0010, "stuck");

    // Done rise coinciding with the last timeout cycle, then one cycle late
    req_cmd = 16'h0005;
    req = 4'b0001;
    wait_issue(0, 4'h5, "coincide");
    run_resp(0, 4'h5, TIMEOUT, 1'b0, 4'b0001, "coincide");
    req = 4'b0001;
    wait_issue(0, 4'h5, "late");
    run_resp(0, 4'h5, TIMEOUT + 1, 1'b0, 4'b0001, "late");

    // Randomized traffic against the round-robin model
    for (int t = 0; t < 30; t++) begin
      req = req | NREQ'($urandom_range(0, 15));
      if (req == '0) req = NREQ'(1) << $urandom_range(0, NREQ - 1);
      req_cmd = (NREQ*CMD_W)'($urandom);
      exp = pick(req, last_srv);
      d = $urandom_range(1, TIMEOUT + 3);
      wait_issue(exp, slice(exp), "rand");
      if ($urandom_range(0, 3) == 0) req[exp] = 1'b0;
      run_resp(exp, slice(exp), d, 1'b0, NREQ'(1) << exp, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simple_bus_arb.md
Name: simple_bus_arb

Overview:
- Round-robin arbiter and sequencer that shares one simple_bus command port between NREQ requesters.
- Per transaction: selects a requester, issues a single-cycle en/cmd pulse to the bus, waits for completion (a done rising edge) or a timeout, then returns a one-cycle ack or err to that requester.
- Sits between the requester agents and the simple_bus instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CMD_W, 4, command width; must match the simple_bus cmd width.
- TIMEOUT, 32, cycles in WAIT before an err is returned (>=2).
- TO_W, 6, timeout counter width; must satisfy 2**TO_W > TIMEOUT.

Ports:
- clk  input  1  Clock; all logic on posedge.
- rst_  input  1  Asynchronous, active-low reset.
- req  input  NREQ  Per-requester request level; held high until ack/err.
- req_cmd  input  NREQ*CMD_W  Packed commands; requester i uses bits [i*CMD_W +: CMD_W].
- gnt  output  NREQ  One-hot grant; held from ISSUE through RESP.
- ack  output  NREQ  One-cycle pulse to the granted requester on completion.
- err  output  NREQ  One-cycle pulse to the granted requester on timeout.
- bus_en  output  1  Drives simple_bus en; high exactly one cycle per transaction.
- bus_cmd  output  CMD_W  Drives simple_bus cmd; valid when bus_en=1, otherwise holds the last value.
- bus_done  input  1  From simple_bus done.
- busy  output  1  High whenever state != IDLE.

Behaviour:
- All outputs are registered.
- Reset (async, rst_=0) forces:
  - state=IDLE;
  - gnt, ack, err, bus_en, busy all 0;
  - bus_cmd=0, done_q=0, to_cnt=0;
  - rr_ptr=NREQ-1, so requester 0 has top priority after reset.
- Reset mid-transaction abandons the transaction: no ack or err is ever issued for it.
- done_q is a register of bus_done, updated every cycle. done_rise = bus_done & ~done_q.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If |req, choose the first i with req[i]=1, searching (rr_ptr+1) mod NREQ upward with wrap.
  - Latch sel=i and cmd_l=req_cmd slice i; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (one cycle):
  - bus_en=1, bus_cmd=cmd_l, gnt=onehot(sel), to_cnt cleared.
  - Next state WAIT.
- WAIT:
  - bus_en=0; to_cnt increments each cycle.
  - done_rise -> RESP with result=OK.
  - Else if to_cnt==TIMEOUT-1 -> RESP with result=ERR.
  - done_rise and timeout in the same cycle -> OK wins.
  - A bus_done that is already high with no edge does not complete the transaction; it ends in a timeout.
- RESP (one cycle):
  - ack[sel]=1 if result=OK, otherwise err[sel]=1.
  - rr_ptr=sel; gnt cleared on exit; next state IDLE.
- Latency:
  - req sampled in IDLE at cycle N -> bus_en high at cycle N+1.
  - done_rise at cycle M -> ack at M+1.
  - Next bus_en earliest at M+3.
- If req drops while granted, the transaction still runs to completion and ack/err still pulses. cmd_l is not re-sampled.
- Fairness: a requester holding req continuously is granted within NREQ transactions.
- Only one transaction is outstanding at a time; there is no pipelining of commands.

Decomposition:
- Package simple_bus_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - CMD_W default constant;
  - result encoding (OK, ERR).
- One sub-module, rr_pick: combinational round-robin selector. Inputs: req vector, rr_ptr. Outputs: valid, index. Reusable by other arbiters.

Test Plan:
- Single request: reset; req=4'b0010 with cmd slice 1 = 4'hA.
  - Expected: bus_en one cycle later with bus_cmd=4'hA and gnt=4'b0010.
  - bus_done rises 17 cycles later -> ack=4'b0010 for exactly one cycle; busy returns to 0.
- Round-robin: req=4'b1111 held, done returned each time.
  - Expected grant order 0,1,2,3,0, with each bus_cmd matching that requester's slice.
- Timeout: req[2] with bus_done held 0.
  - Expected: err=4'b0100 exactly TIMEOUT+1 cycles after bus_en; ack never asserted.
- Stuck-high done: bus_done=1 before ISSUE and held high.
  - Expected: timeout err, not ack.
- Coincident events: done_rise on the same cycle that to_cnt reaches TIMEOUT-1.
  - Expected: ack, and no err.
- Reset mid-WAIT: assert rst_=0 during WAIT.
  - Expected: all outputs 0 immediately (asynchronous).
  - After release with req=4'b1000 and req[0]=1 in the same cycle, requester 0 is granted first.
